// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, IF/ID register (optional FETCH_PERF_CNT_EN counters)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        PCWr,
   input  logic        IF_ID_Wr,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] IF_ID_PC,
   output logic [31:0] IF_ID_inst,
   output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_fetch_q, pc_fetch_d;
   logic        buf_valid_q, buf_valid_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_inst_q, buf_inst_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic        if_valid_q, if_valid_d;
   logic        run_q;
   logic        resp_live;

   // Requests start only once an edge has seen reset released, and never while the buffer is occupied.
   assign imem_req  = rstn && run_q && (state_q == S_REQ) && !buf_valid_q && PCWr && !flush;
   assign imem_addr = pc_q;
   // Only a response belonging to a live (non-dropped) request may be routed.
   assign resp_live = imem_rvalid && (state_q == S_WAIT);

   assign IF_ID_PC    = if_pc_q;
   assign IF_ID_inst  = if_inst_q;
   assign IF_ID_valid = if_valid_q;

   // Next-state: FSM, PC, response buffer and IF/ID; flush takes priority over both stalls.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pc_fetch_d  = pc_fetch_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_inst_d  = buf_inst_q;
      if_pc_d     = if_pc_q;
      if_inst_d   = if_inst_q;
      if_valid_d  = if_valid_q;

      if (flush) begin
         pc_d        = redirect_pc;
         buf_valid_d = 1'b0;
         if_pc_d     = 32'h0;
         if_inst_d   = NOP_INST;
         if_valid_d  = 1'b0;
         // A response in the flush cycle completes the stale request; otherwise wait for it in DROP.
         if (state_q != S_REQ && imem_rvalid) begin
            state_d = S_REQ;
         end else if (state_q == S_WAIT) begin
            state_d = S_DROP;
         end
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_req && imem_gnt) begin
                  pc_fetch_d = pc_q;
                  pc_d       = pc_q + 32'd4;
                  state_d    = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) state_d = S_REQ;
            end
            S_DROP: begin
               if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase

         if (IF_ID_Wr) begin
            if (buf_valid_q) begin
               if_pc_d     = buf_pc_q;
               if_inst_d   = buf_inst_q;
               if_valid_d  = 1'b1;
               buf_valid_d = resp_live;
               if (resp_live) begin
                  buf_pc_d   = pc_fetch_q;
                  buf_inst_d = imem_rdata;
               end
            end else if (resp_live) begin
               if_pc_d    = pc_fetch_q;
               if_inst_d  = imem_rdata;
               if_valid_d = 1'b1;
            end else begin
               if_pc_d    = 32'h0;
               if_inst_d  = NOP_INST;
               if_valid_d = 1'b0;
            end
         end else if (resp_live) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_fetch_q;
            buf_inst_d  = imem_rdata;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         pc_fetch_q  <= RESET_PC;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= 32'h0;
         buf_inst_q  <= NOP_INST;
         if_pc_q     <= 32'h0;
         if_inst_q   <= NOP_INST;
         if_valid_q  <= 1'b0;
         run_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pc_fetch_q  <= pc_fetch_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_inst_q  <= buf_inst_d;
         if_pc_q     <= if_pc_d;
         if_inst_q   <= if_inst_d;
         if_valid_q  <= if_valid_d;
         run_q       <= 1'b1;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] flush_cnt_q;

   // Free-running event counters for IF/ID stall cycles and flush cycles.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         if (!IF_ID_Wr) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush)     flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic        PCWr;
   logic        IF_ID_Wr;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_PC;
   logic [31:0] IF_ID_inst;
   logic        IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   fetch_unit dut (
      .clk         (clk),
      .rstn        (rstn),
      .PCWr        (PCWr),
      .IF_ID_Wr    (IF_ID_Wr),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .IF_ID_PC    (IF_ID_PC),
      .IF_ID_inst  (IF_ID_inst),
      .IF_ID_valid (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
     ,.stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] inst, input logic v);
      chk({tag, "_pc"},    IF_ID_PC,           pc);
      chk({tag, "_inst"},  IF_ID_inst,         inst);
      chk({tag, "_valid"}, {31'h0, IF_ID_valid}, {31'h0, v});
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
      chk({tag, "_req"}, {31'h0, imem_req}, {31'h0, r});
      if (r) chk({tag, "_addr"}, imem_addr, a);
   endtask

   // Advance one clock; returns 1ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Apply inputs for the coming cycle and let combinational outputs settle.
   task automatic drive(input logic pcwr, input logic ifw, input logic fl, input logic [31:0] rpc,
                        input logic g, input logic rv, input logic [31:0] rd);
      PCWr        = pcwr;
      IF_ID_Wr    = ifw;
      flush       = fl;
      redirect_pc = rpc;
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rd;
      #1;
   endtask

   initial begin
      rstn = 1'b0;
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      cyc();
      cyc();

      // Reset state
      chk_req("rst", 1'b0, 32'h0);
      chk_ifid("rst", 32'h0, NOP, 1'b0);
      rstn = 1'b1;
      #1;
      chk_req("rel_same_cycle", 1'b0, 32'h0);
      cyc();

      // 1-cycle memory, two instructions
      chk_req("f0", 1'b1, 32'h0);
      drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 1, 32'h0050_0093);
      chk_req("f0_wait", 1'b0, 32'h0);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_ifid("i0", 32'h0, 32'h0050_0093, 1'b1);
      chk_req("f1", 1'b1, 32'h4);
      drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
      cyc();
      chk_ifid("bub0", 32'h0, NOP, 1'b0);
      drive(1, 1, 0, 32'h0, 0, 1, 32'h00A0_0113);
      cyc();
      chk_ifid("i1", 32'h4, 32'h00A0_0113, 1'b1);

      // Stall: response lands in the buffer while IF/ID holds
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chk_req("f2", 1'b1, 32'h8);
      cyc();
      drive(0, 0, 0, 32'h0, 0, 1, 32'h1111_1111);
      cyc();
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      chk_ifid("hold1", 32'h4, 32'h00A0_0113, 1'b1);
      chk_req("stall1", 1'b0, 32'h0);
      cyc();
      chk_req("stall2", 1'b0, 32'h0);
      cyc();
      chk_ifid("hold3", 32'h4, 32'h00A0_0113, 1'b1);
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_req("buf_full", 1'b0, 32'h0);
      cyc();
      chk_ifid("from_buf", 32'h8, 32'h1111_1111, 1'b1);

      // Flush in WAIT, stale response two cycles later
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chk_req("f3", 1'b1, 32'hC);
      cyc();
      drive(0, 0, 1, 32'h100, 0, 0, 32'h0);
      chk_req("flush_req", 1'b0, 32'h0);
      cyc();
      chk_ifid("flush", 32'h0, NOP, 1'b0);
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_req("drop1", 1'b0, 32'h0);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
      cyc();
      chk_ifid("dropped", 32'h0, NOP, 1'b0);
      drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
      chk_req("redir", 1'b1, 32'h100);
      cyc();
      chk_ifid("redir_wait", 32'h0, NOP, 1'b0);
      drive(1, 1, 0, 32'h0, 0, 1, 32'h0000_0513);
      cyc();
      chk_ifid("i100", 32'h100, 32'h0000_0513, 1'b1);

      // Flush and response in the same cycle
      drive(1, 0, 0, 32'h0, 1, 0, 32'h0);
      chk_req("f104", 1'b1, 32'h104);
      cyc();
      drive(1, 1, 1, 32'h200, 0, 1, 32'h0BAD_0BAD);
      cyc();
      chk_ifid("fl_rv", 32'h0, NOP, 1'b0);
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_req("after_fl_rv", 1'b1, 32'h200);

      // Grant withheld for 4 cycles
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_req($sformatf("nogt%0d", i), 1'b1, 32'h200);
         chk({$sformatf("nogt%0d", i), "_valid"}, {31'h0, IF_ID_valid}, 32'h0);
      end
      drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 1, 32'h1234_5678);
      cyc();
      chk_ifid("i200", 32'h200, 32'h1234_5678, 1'b1);
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_req("f204", 1'b1, 32'h204);

      // PC wraps modulo 2^32
      drive(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
      cyc();
      drive(1, 1, 0, 32'h0, 1, 0, 32'h0);
      chk_req("ftop", 1'b1, 32'hFFFF_FFFC);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 1, 32'hCAFE_0001);
      cyc();
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      chk_ifid("itop", 32'hFFFF_FFFC, 32'hCAFE_0001, 1'b1);
      chk_req("wrap", 1'b1, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      rstn = 1'b0;
      cyc();
      chk("perf_rst_stall", stall_cnt, 32'h0);
      chk("perf_rst_flush", flush_cnt, 32'h0);
      rstn = 1'b1;
      drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) cyc();
      drive(1, 1, 1, 32'h40, 0, 0, 32'h0);
      for (int i = 0; i < 2; i++) cyc();
      drive(1, 1, 0, 32'h0, 0, 0, 32'h0);
      cyc();
      chk("perf_stall", stall_cnt, 32'd5);
      chk("perf_flush", flush_cnt, 32'd2);
      rstn = 1'b0;
      cyc();
      chk("perf_clr_stall", stall_cnt, 32'h0);
      chk("perf_clr_flush", flush_cnt, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction-fetch stage of the 5-stage pipeline: owns the PC register, the instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes the stall controls PCWr and IF_ID_Wr from the load-use hazard unit, and the branch/jump redirect from EX.
- Produces IF_ID_PC, IF_ID_inst and IF_ID_valid for decode.
- Tolerates variable instruction-memory latency: at most one outstanding request, plus a one-entry response buffer.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset
- PCWr  in  1  0 = hold PC and issue no new request (hazard stall)
- IF_ID_Wr  in  1  0 = hold IF/ID contents
- flush  in  1  taken branch/jump from EX; overrides stalls
- redirect_pc  in  32  target address, valid when flush=1
- imem_req  out  1  request valid (combinational)
- imem_addr  out  32  request address = pc register
- imem_gnt  in  1  request accepted in the same cycle when imem_req=1
- imem_rvalid  in  1  response valid, exactly once per granted request
- imem_rdata  in  32  instruction word
- IF_ID_PC  out  32  PC of the instruction in IF/ID
- IF_ID_inst  out  32  instruction in IF/ID
- IF_ID_valid  out  1  0 = bubble

## Operation

**State machine** (states REQ, WAIT, DROP):
- REQ: imem_req = buf empty && PCWr && !flush. Handshake fires when imem_req && imem_gnt; then pc_fetch <= pc, pc <= pc+4 (32-bit wrap), go to WAIT. There is no obligation to hold a request that is not granted.
- WAIT: on imem_rvalid, route the response and go to REQ.
- DROP: on imem_rvalid, discard the response and go to REQ.

**Flush:**
- pc <= redirect_pc; buffer cleared; IF/ID <= {0, NOP_INST, valid=0}.
- In WAIT: go to DROP; if imem_rvalid arrives in the same cycle, discard it and go to REQ instead.
- In DROP: pc is updated and the state is unchanged.

**Response routing:** if IF_ID_Wr=1 and buf is empty, write IF/ID directly with {pc_fetch, imem_rdata, 1}. Otherwise store {pc_fetch, imem_rdata} in buf.

**IF/ID update when IF_ID_Wr=1 and flush=0:**
- Buf full: load from buf and clear buf. A response arriving in that same cycle goes into buf.
- Else, imem_rvalid=1: load the response.
- Else: load a bubble.

**IF/ID when IF_ID_Wr=0:** hold all three IF/ID outputs.

## Timing
- Reset (rstn=0 at an edge): pc=RESET_PC, state=REQ, buf empty, IF_ID_PC=0, IF_ID_inst=NOP_INST, IF_ID_valid=0.
- imem_req is low while rstn=0 and first rises in the cycle after rstn samples 1.
- Latency: a response with imem_rvalid in cycle N appears on IF/ID after edge N, provided IF_ID_Wr=1 and buf is empty.
- Throughput with a 1-cycle memory: one instruction per 2 cycles.
- Reset mid-operation: an outstanding response is not tracked after reset. The memory must drop it; the bench must not send it.
- Flush has priority over PCWr=0 and IF_ID_Wr=0 in the same cycle.

## Configuration
- FETCH_PERF_CNT_EN defined: adds two outputs, stall_cnt (out, 32) and flush_cnt (out, 32).
  - stall_cnt increments on every cycle with IF_ID_Wr=0 && rstn.
  - flush_cnt increments on every cycle with flush=1.
  - Both reset to 0 and wrap modulo 2^32.
- Not defined: both ports and both counters are absent; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0, then a 1-cycle memory returning 0x00500093 and 0x00A00113 -> imem_addr 0x0 then 0x4; IF/ID shows {0x0, 0x00500093, 1}, then a bubble, then {0x4, 0x00A00113, 1}.
- IF_ID_Wr=0 and PCWr=0 for 3 cycles while a response arrives -> response goes to buf, IF/ID holds, imem_req stays 0; on release, IF/ID loads the buffered instruction first.
- flush with redirect_pc=0x100 while in WAIT, response arriving 2 cycles later -> that response is discarded; next imem_addr=0x100; IF_ID_valid=0 until the 0x100 instruction arrives.
- flush and imem_rvalid in the same cycle -> response dropped; state REQ; next request at redirect_pc.
- imem_gnt held low for 4 cycles -> imem_addr stable at pc; pc does not advance; IF/ID fills with bubbles.
- With FETCH_PERF_CNT_EN: 5 stall cycles and 2 flushes -> stall_cnt=5, flush_cnt=2; both return to 0 after rstn=0.
